header_word_server: RTL and testbench

- Upstream stage of sha256d_wrapper.
- Holds one 80-byte Bitcoin block header, loaded byte-serially from the chip pins.
- Serves it as 32-bit big-endian words on the wrapper's addr/rq/data/rdy request interface.
- Substitutes header word 19 with an internal nonce counter that the controller advances after each hash attempt.

---
 rtl/hdr_pkg.sv | 32 +++
 rtl/nonce_counter.sv | 78 +++++++
 rtl/header_word_server.sv | 192 +++++++++++++++++++
 tb/tb_header_word_server.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdr_pkg.sv
// Shared definitions for the header word server: header geometry,
// FSM state encoding and small word-packing helpers.
package hdr_pkg;

    localparam int HDR_BYTES   = 80;
    localparam int HDR_WORDS   = 20;
    localparam int NONCE_WORD  = 19;
    localparam int NONCE_BYTE0 = 76;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_READY = 2'd1,
        S_SERVE = 2'd2
    } hdr_state_e;

    // Four header bytes to one big-endian word, first byte in bits 31:24.
    function automatic logic [31:0] pack_be(
        input logic [7:0] b0,
        input logic [7:0] b1,
        input logic [7:0] b2,
        input logic [7:0] b3
    );
        return {b0, b1, b2, b3};
    endfunction

    // The nonce is kept numerically but travels little-endian in the header,
    // so word 19 is its byte-reversed image.
    function automatic logic [31:0] nonce_to_word(input logic [31:0] n);
        return {n[7:0], n[15:8], n[23:16], n[31:24]};
    endfunction

endpackage

// File: rtl/nonce_counter.sv
// Nonce register for the header word server: byte-wise load from the
// header stream, increment, synchronous clear and the sticky exhausted flag.
// Optional feature macro: NONCE_RANGE_EN (stop at nonce_limit instead of
// wrapping at 32'hFFFF_FFFF).
module nonce_counter #(
    parameter logic [31:0] NONCE_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        ld_en,
    input  logic [1:0]  ld_sel,
    input  logic [7:0]  ld_byte,
    input  logic        inc,
`ifdef NONCE_RANGE_EN
    input  logic [31:0] nonce_limit,
`endif
    output logic [31:0] nonce,
    output logic        exhausted
);

    logic [31:0] nonce_r;
    logic [31:0] nonce_next_s;
    logic        exhausted_r;
    logic        exhausted_next_s;

    // Next nonce/flag: a header byte write wins over an increment in the same cycle.
    always_comb begin
        nonce_next_s     = nonce_r;
        exhausted_next_s = exhausted_r;
        if (ld_en) begin
            case (ld_sel)
                2'd0:    nonce_next_s[7:0]   = ld_byte;
                2'd1:    nonce_next_s[15:8]  = ld_byte;
                2'd2:    nonce_next_s[23:16] = ld_byte;
                2'd3:    nonce_next_s[31:24] = ld_byte;
                default: nonce_next_s        = nonce_r;
            endcase
        end else if (inc) begin
`ifdef NONCE_RANGE_EN
            if (exhausted_r) begin
                nonce_next_s = nonce_r;
            end else if (nonce_r == nonce_limit) begin
                exhausted_next_s = 1'b1;
            end else begin
                nonce_next_s = nonce_r + 32'd1;
            end
`else
            if (nonce_r == 32'hFFFF_FFFF) begin
                exhausted_next_s = 1'b1;
            end else begin
                exhausted_next_s = exhausted_r;
            end
            nonce_next_s = nonce_r + 32'd1;
`endif
        end else begin
            nonce_next_s = nonce_r;
        end
    end

    // Nonce and exhausted registers; clear behaves like reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nonce_r     <= NONCE_RST;
            exhausted_r <= 1'b0;
        end else if (clear) begin
            nonce_r     <= NONCE_RST;
            exhausted_r <= 1'b0;
        end else begin
            nonce_r     <= nonce_next_s;
            exhausted_r <= exhausted_next_s;
        end
    end

    assign nonce     = nonce_r;
    assign exhausted = exhausted_r;

endmodule

// File: rtl/header_word_server.sv
// Header word server: captures an 80-byte block header byte-serially and
// serves it as big-endian 32-bit words on an addr/rq/data/rdy interface,
// with word 19 replaced by the live nonce counter.
// Optional feature macro: NONCE_RANGE_EN (adds nonce_limit input).
module header_word_server
    import hdr_pkg::*;
#(
    parameter logic [31:0] NONCE_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        loaded,
    input  logic [4:0]  addr,
    input  logic        rq,
    output logic [31:0] data,
    output logic        rdy,
    input  logic        next_nonce,
`ifdef NONCE_RANGE_EN
    input  logic [31:0] nonce_limit,
`endif
    output logic [31:0] nonce,
    output logic        exhausted
);

    hdr_state_e  state_r;
    hdr_state_e  state_next_s;
    logic [7:0]  hdr_mem_r [0:HDR_BYTES-1];
    logic [6:0]  ptr_r;
    logic        rq_d_r;
    logic        loaded_r;
    logic [31:0] data_r;
    logic        rdy_r;

    logic        rq_edge_s;
    logic        ld_take_s;
    logic        last_byte_s;
    logic        serve_start_s;
    logic        nonce_ld_s;
    logic [6:0]  base_s;
    logic [31:0] word_sel_s;
    logic [31:0] nonce_s;

    // Request edge, byte acceptance and serve-start qualifiers.
    always_comb begin
        rq_edge_s     = rq & ~rq_d_r;
        ld_take_s     = (state_r == S_EMPTY) & ld_valid;
        last_byte_s   = ld_take_s & (ptr_r == 7'(HDR_BYTES - 1));
        serve_start_s = (state_r == S_READY) & rq_edge_s;
        nonce_ld_s    = ld_take_s & (ptr_r >= 7'(NONCE_BYTE0));
    end

    // Next-state logic; S_SERVE always lasts exactly one cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_EMPTY: begin
                if (last_byte_s) begin
                    state_next_s = S_READY;
                end else begin
                    state_next_s = S_EMPTY;
                end
            end
            S_READY: begin
                if (rq_edge_s) begin
                    state_next_s = S_SERVE;
                end else begin
                    state_next_s = S_READY;
                end
            end
            S_SERVE: state_next_s = S_READY;
            default: state_next_s = S_EMPTY;
        endcase
    end

    // State register; clear forces the empty state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_EMPTY;
        end else if (clear) begin
            state_r <= S_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Word mux; the word is captured on the request edge so a coincident
    // nonce advance cannot leak into the served value.
    always_comb begin
        base_s     = {addr, 2'b00};
        word_sel_s = 32'h0000_0000;
        if (addr < 5'(NONCE_WORD)) begin
            word_sel_s = pack_be(hdr_mem_r[base_s],
                                 hdr_mem_r[base_s + 7'd1],
                                 hdr_mem_r[base_s + 7'd2],
                                 hdr_mem_r[base_s + 7'd3]);
        end else if (addr == 5'(NONCE_WORD)) begin
            word_sel_s = nonce_to_word(nonce_s);
        end else begin
            word_sel_s = 32'h0000_0000;
        end
    end

    // Header byte storage; clear deliberately leaves the contents in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HDR_BYTES; i++) begin
                hdr_mem_r[i] <= 8'h00;
            end
        end else if (clear) begin
            hdr_mem_r <= hdr_mem_r;
        end else if (ld_take_s) begin
            hdr_mem_r[ptr_r] <= ld_data;
        end else begin
            hdr_mem_r <= hdr_mem_r;
        end
    end

    // Byte pointer and loaded flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r    <= 7'd0;
            loaded_r <= 1'b0;
        end else if (clear) begin
            ptr_r    <= 7'd0;
            loaded_r <= 1'b0;
        end else begin
            if (ld_take_s) begin
                ptr_r <= ptr_r + 7'd1;
            end else begin
                ptr_r <= ptr_r;
            end
            if (last_byte_s) begin
                loaded_r <= 1'b1;
            end else begin
                loaded_r <= loaded_r;
            end
        end
    end

    // Previous-cycle rq, tracked in every state so a level held across
    // loading does not count as a fresh edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq_d_r <= 1'b0;
        end else begin
            rq_d_r <= rq;
        end
    end

    // Served word and one-cycle rdy pulse; data holds between serves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= 32'h0000_0000;
            rdy_r  <= 1'b0;
        end else if (clear) begin
            data_r <= data_r;
            rdy_r  <= 1'b0;
        end else if (serve_start_s) begin
            data_r <= word_sel_s;
            rdy_r  <= 1'b1;
        end else begin
            data_r <= data_r;
            rdy_r  <= 1'b0;
        end
    end

    nonce_counter #(
        .NONCE_RST   (NONCE_RST)
    ) u_nonce (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .ld_en       (nonce_ld_s),
        .ld_sel      (ptr_r[1:0]),
        .ld_byte     (ld_data),
        .inc         (next_nonce),
`ifdef NONCE_RANGE_EN
        .nonce_limit (nonce_limit),
`endif
        .nonce       (nonce_s),
        .exhausted   (exhausted)
    );

    assign loaded = loaded_r;
    assign data   = data_r;
    assign rdy    = rdy_r;
    assign nonce  = nonce_s;

endmodule

// File: tb/tb_header_word_server.sv
// Self-checking bench for header_word_server: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// behavioural header/nonce model. Honours NONCE_RANGE_EN.
module tb_header_word_server;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = 8'h00;
    logic [4:0]  addr = 5'd0;
    logic        rq = 1'b0;
    logic        next_nonce = 1'b0;
    logic        loaded;
    logic [31:0] data;
    logic        rdy;
    logic [31:0] nonce;
    logic        exhausted;
`ifdef NONCE_RANGE_EN
    logic [31:0] nonce_limit = 32'hFFFF_FFFF;
`endif

    int checks = 0;
    int failures = 0;

    // behavioural model state
    logic [7:0]  m_mem [0:79];
    int          m_ptr;
    bit          m_loaded, m_rdy, m_exh, m_prev_rq;
    logic [31:0] m_data, m_nonce;

    logic [7:0]  hdr [0:79];

    always #5 clk = ~clk;

    header_word_server dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .loaded     (loaded),
        .addr       (addr),
        .rq         (rq),
        .data       (data),
        .rdy        (rdy),
        .next_nonce (next_nonce),
`ifdef NONCE_RANGE_EN
        .nonce_limit(nonce_limit),
`endif
        .nonce      (nonce),
        .exhausted  (exhausted)
    );

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_word(input int a);
        if (a < 19) return {m_mem[4*a], m_mem[4*a+1], m_mem[4*a+2], m_mem[4*a+3]};
        if (a == 19) return {m_nonce[7:0], m_nonce[15:8], m_nonce[23:16], m_nonce[31:24]};
        return 32'h0;
    endfunction

    function automatic void m_reset();
        m_ptr = 0; m_loaded = 0; m_rdy = 0; m_exh = 0; m_prev_rq = 0;
        m_data = 32'h0; m_nonce = 32'h0;
    endfunction

    // Apply one clock edge of the header/nonce rules to the model, using the
    // inputs that the coming edge will sample.
    function automatic void m_advance();
        bit nonce_byte = 0;
        bit nxt_rdy = 0;
        if (clear) begin
            m_ptr = 0; m_loaded = 0; m_rdy = 0; m_exh = 0;
            m_nonce = 32'h0; m_prev_rq = rq;
            return;
        end
        if (!m_loaded) begin
            if (ld_valid) begin
                m_mem[m_ptr] = ld_data;
                if (m_ptr >= 76) begin
                    m_nonce[(m_ptr-76)*8 +: 8] = ld_data;
                    nonce_byte = 1;
                end
                m_ptr++;
                if (m_ptr == 80) m_loaded = 1;
            end
        end else if (!m_rdy && rq && !m_prev_rq) begin
            m_data = m_word(int'(addr));
            nxt_rdy = 1;
        end
        if (next_nonce && !nonce_byte) begin
`ifdef NONCE_RANGE_EN
            if (!m_exh) begin
                if (m_nonce == nonce_limit) m_exh = 1;
                else m_nonce = m_nonce + 32'd1;
            end
`else
            if (m_nonce == 32'hFFFF_FFFF) m_exh = 1;
            m_nonce = m_nonce + 32'd1;
`endif
        end
        m_rdy = nxt_rdy;
        m_prev_rq = rq;
    endfunction

    // Compare process: check all outputs at every falling edge, then advance.
    initial begin
        m_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) m_reset();
            check32("loaded", 32'(loaded), 32'(m_loaded));
            check32("rdy", 32'(rdy), 32'(m_rdy));
            check32("data", data, m_data);
            check32("nonce", nonce, m_nonce);
            check32("exhausted", 32'(exhausted), 32'(m_exh));
            if (rst_n) m_advance();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_range(input int from, input int to);
        for (int i = from; i <= to; i++) begin
            ld_valid = 1'b1;
            ld_data  = hdr[i];
            step();
        end
        ld_valid = 1'b0;
    endtask

    task automatic request(input int a, input bit nn, output logic [31:0] d, output logic r);
        addr = 5'(a);
        rq = 1'b1;
        next_nonce = nn;
        step();
        d = data;
        r = rdy;
        rq = 1'b0;
        next_nonce = 1'b0;
        step();
        step();
    endtask

    task automatic pulse_next();
        next_nonce = 1'b1;
        step();
        next_nonce = 1'b0;
        step();
    endtask

    initial begin
        logic [31:0] d;
        logic        r;
        logic [31:0] old_n;
        int          cnt;

        // 1: reset, sequential header, word 0
        repeat (3) step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 80; i++) hdr[i] = 8'(i);
        load_range(0, 78);
        check32("loaded_before_last", 32'(loaded), 32'd0);
        load_range(79, 79);
        check32("loaded_after_last", 32'(loaded), 32'd1);
        request(0, 1'b0, d, r);
        check32("w0_rdy", 32'(r), 32'd1);
        check32("w0_data", d, 32'h0001_0203);

        // 2: nonce word before and after one advance
        request(19, 1'b0, d, r);
        check32("w19_data", d, 32'h4C4D_4E4F);
        check32("w19_nonce", nonce, 32'h4F4E_4D4C);
        pulse_next();
        check32("nonce_plus1", nonce, 32'h4F4E_4D4D);
        request(19, 1'b0, d, r);
        check32("w19_after_inc", d, 32'h4D4D_4E4F);

`ifdef NONCE_RANGE_EN
        // 6: limited range stops and holds
        nonce_limit = 32'h4F4E_4D4E;
        pulse_next();
        check32("rng_nonce1", nonce, 32'h4F4E_4D4E);
        check32("rng_exh1", 32'(exhausted), 32'd0);
        pulse_next();
        check32("rng_nonce2", nonce, 32'h4F4E_4D4E);
        check32("rng_exh2", 32'(exhausted), 32'd1);
        pulse_next();
        check32("rng_nonce3", nonce, 32'h4F4E_4D4E);
        check32("rng_exh3", 32'(exhausted), 32'd1);
`endif

        // 3: all-ones nonce, exhaustion, then clear
        clear = 1'b1;
        step();
        clear = 1'b0;
`ifdef NONCE_RANGE_EN
        nonce_limit = 32'hFFFF_FFFF;
`endif
        for (int i = 76; i < 80; i++) hdr[i] = 8'hFF;
        load_range(0, 79);
        pulse_next();
`ifdef NONCE_RANGE_EN
        check32("ff_nonce", nonce, 32'hFFFF_FFFF);
`else
        check32("ff_nonce", nonce, 32'h0000_0000);
`endif
        check32("ff_exh", 32'(exhausted), 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check32("clr_loaded", 32'(loaded), 32'd0);
        check32("clr_exh", 32'(exhausted), 32'd0);
        request(0, 1'b0, d, r);
        check32("clr_no_rdy", 32'(r), 32'd0);

        // 4: rq edge during load, then held rq yields one pulse
        for (int i = 0; i < 80; i++) hdr[i] = 8'($urandom);
        load_range(0, 39);
        request(3, 1'b0, d, r);
        check32("empty_no_rdy", 32'(r), 32'd0);
        load_range(40, 79);
        check32("loaded_split", 32'(loaded), 32'd1);
        request(7, 1'b0, d, r);
        check32("w7_data", d, {hdr[28], hdr[29], hdr[30], hdr[31]});
        addr = 5'd5;
        rq = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rdy) cnt++;
        end
        rq = 1'b0;
        step();
        check32("held_rq_pulses", 32'(cnt), 32'd1);

        // 5: word-19 serve coinciding with advance; out-of-range address
        old_n = {hdr[79], hdr[78], hdr[77], hdr[76]};
        request(19, 1'b1, d, r);
        check32("coinc_data", d, {hdr[76], hdr[77], hdr[78], hdr[79]});
        check32("coinc_nonce", nonce, old_n + 32'd1);
        request(25, 1'b0, d, r);
        check32("a25_rdy", 32'(r), 32'd1);
        check32("a25_data", d, 32'h0);

        // randomized phase, with one mid-run reset
        for (int i = 0; i < 2000; i++) begin
            clear      = ($urandom_range(0, 299) == 0);
            ld_valid   = 1'($urandom_range(0, 1));
            ld_data    = 8'($urandom);
            addr       = 5'($urandom_range(0, 23));
            if ($urandom_range(0, 2) == 0) rq = ~rq;
            next_nonce = ($urandom_range(0, 7) == 0);
            if (i == 1000) rst_n = 1'b0;
            if (i == 1002) rst_n = 1'b1;
            step();
        end
        clear = 1'b0; ld_valid = 1'b0; rq = 1'b0; next_nonce = 1'b0;
        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
